decode_issue: RTL and testbench

//  Five-stage CPU decode/issue stage. Sits directly after fetch: consumes IF_ID_bus {pc,inst}.

---
 rtl/decode_issue_if.sv | 35 +++
 rtl/decode_issue.sv | 184 ++++++++++++++++++
 tb/tb_decode_issue.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_if.sv
// Decode/issue stage boundary: fetch-side handshake, EXE-side handshake,
// pending write-destination scoreboard inputs and regfile read port.
// "slave" is the decode/issue stage; "master" is the surrounding pipeline.
interface decode_issue_if #(
  parameter int STALL_CNT_W = 32
);
  logic                   IF_over;
  logic [63:0]            IF_ID_bus;
  logic                   cancel;
  logic                   EXE_allow_in;
  logic [4:0]             EXE_wdest;
  logic [4:0]             MEM_wdest;
  logic [4:0]             WB_wdest;
  logic [31:0]            rs_value;
  logic [31:0]            rt_value;
  logic [4:0]             rs;
  logic [4:0]             rt;
  logic                   ID_allow_in;
  logic                   ID_over;
  logic [32:0]            jbr_bus;
  logic [127:0]           ID_EXE_bus;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output IF_over, IF_ID_bus, cancel, EXE_allow_in,
    output EXE_wdest, MEM_wdest, WB_wdest, rs_value, rt_value,
    input  rs, rt, ID_allow_in, ID_over, jbr_bus, ID_EXE_bus, stall_cnt
  );

  modport slave (
    input  IF_over, IF_ID_bus, cancel, EXE_allow_in,
    input  EXE_wdest, MEM_wdest, WB_wdest, rs_value, rt_value,
    output rs, rt, ID_allow_in, ID_over, jbr_bus, ID_EXE_bus, stall_cnt
  );
endinterface

// File: rtl/decode_issue.sv
// Decode/issue stage of a five-stage MIPS-style pipeline.
// Holds one instruction, stalls it on RAW hazards against EXE/MEM/WB
// destinations, resolves branches/jumps and hands {pc,inst,rs,rt} to EXE.
// Build option: define ID_STALL_CNT_EN to build the saturating hazard-stall
// counter; otherwise stall_cnt is tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no instruction held; stage accepts from fetch
// ST_HELD  | instruction held; waits for hazards and EXE
module decode_issue #(
  parameter int STALL_CNT_W = 32
) (
  input logic          clk,
  input logic          resetn,
  decode_issue_if.slave io
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  logic        id_valid;
  logic        hazard;
  logic        id_over;
  logic        id_allow_in;
  logic        rs_used;
  logic        rt_used;
  logic        br_cond;
  logic [31:0] br_target;
  logic        jbr_taken;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs_a;
  logic [4:0]  rt_a;
  logic [31:0] seq_pc;
  logic [31:0] b_target;
  logic [31:0] j_target;

  assign op       = inst_q[31:26];
  assign funct    = inst_q[5:0];
  assign rs_a     = inst_q[25:21];
  assign rt_a     = inst_q[20:16];
  assign seq_pc   = pc_q + 32'd4;
  assign b_target = seq_pc + {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
  assign j_target = {seq_pc[31:28], inst_q[25:0], 2'b00};

  assign id_valid    = (state_q == ST_HELD);
  assign id_over     = id_valid && !hazard && !io.cancel;
  assign id_allow_in = !id_valid || (id_over && io.EXE_allow_in);
  assign jbr_taken   = id_over && br_cond;

  assign io.rs          = rs_a;
  assign io.rt          = rt_a;
  assign io.ID_over     = id_over;
  assign io.ID_allow_in = id_allow_in;
  assign io.jbr_bus     = {jbr_taken, jbr_taken ? br_target : 32'd0};
  assign io.ID_EXE_bus  = {pc_q, inst_q, io.rs_value, io.rt_value};

  // Which register fields the held instruction actually reads.
  always_comb begin
    rs_used = 1'b1;
    rt_used = 1'b0;
    case (op)
      6'h00: begin
        rt_used = 1'b1;
        if (funct == 6'h00 || funct == 6'h02 || funct == 6'h03) rs_used = 1'b0;
      end
      6'h02, 6'h03, 6'h0F: rs_used = 1'b0;
      6'h04, 6'h05:        rt_used = 1'b1;
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: rt_used = 1'b1;
      default: ;
    endcase
  end

  // RAW check against every in-flight destination; $0 is never a dependency.
  always_comb begin
    hazard = 1'b0;
    if (rs_used && rs_a != 5'd0 &&
        (rs_a == io.EXE_wdest || rs_a == io.MEM_wdest || rs_a == io.WB_wdest))
      hazard = 1'b1;
    if (rt_used && rt_a != 5'd0 &&
        (rt_a == io.EXE_wdest || rt_a == io.MEM_wdest || rt_a == io.WB_wdest))
      hazard = 1'b1;
    hazard = hazard && id_valid;
  end

  // Branch/jump condition and destination for the held instruction.
  always_comb begin
    br_cond   = 1'b0;
    br_target = 32'd0;
    case (op)
      6'h00: begin
        if (funct == 6'h08 || funct == 6'h09) begin
          br_cond   = 1'b1;
          br_target = io.rs_value;
        end
      end
      6'h01: begin
        br_target = b_target;
        if (rt_a == 5'd0)      br_cond = io.rs_value[31];
        else if (rt_a == 5'd1) br_cond = !io.rs_value[31];
      end
      6'h02, 6'h03: begin
        br_cond   = 1'b1;
        br_target = j_target;
      end
      6'h04: begin
        br_cond   = (io.rs_value == io.rt_value);
        br_target = b_target;
      end
      6'h05: begin
        br_cond   = (io.rs_value != io.rt_value);
        br_target = b_target;
      end
      6'h06: begin
        br_cond   = io.rs_value[31] || (io.rs_value == 32'd0);
        br_target = b_target;
      end
      6'h07: begin
        br_cond   = !io.rs_value[31] && (io.rs_value != 32'd0);
        br_target = b_target;
      end
      default: ;
    endcase
  end

  // Occupancy FSM: cancel kills, a new accept beats a same-cycle retire.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (io.cancel) begin
      state_d = ST_EMPTY;
    end else if (io.IF_over && id_allow_in) begin
      state_d = ST_HELD;
      pc_d    = io.IF_ID_bus[63:32];
      inst_d  = io.IF_ID_bus[31:0];
    end else if (id_over && io.EXE_allow_in) begin
      state_d = ST_EMPTY;
    end
  end

  // Stage registers; reset empties the stage and leaves a NOP at pc 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
      pc_q    <= 32'd0;
      inst_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

`ifdef ID_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Count hazard-stalled cycles, holding at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && stall_cnt_q != {STALL_CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  // Statistics register, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stall_cnt_q <= {STALL_CNT_W{1'b0}};
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign io.stall_cnt = stall_cnt_q;
`else
  assign io.stall_cnt = {STALL_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios followed by randomized traffic,
// every cycle compared against an instruction-level reference model.
module tb_decode_issue;

  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  decode_issue_if #(.STALL_CNT_W(W)) dif ();
  decode_issue #(.STALL_CNT_W(W)) dut (.clk(clk), .resetn(resetn), .io(dif));

  typedef enum {K_OTHER, K_RTYPE, K_SHIFT, K_JR, K_JALR, K_J, K_JAL, K_LUI, K_STORE,
                K_BEQ, K_BNE, K_BLEZ, K_BGTZ, K_BLTZ, K_BGEZ} kind_t;

  int vectors = 0;
  int miscompares = 0;

  bit          m_valid;
  logic [31:0] m_pc, m_inst;
  logic [W-1:0] m_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic kind_t classify(input logic [31:0] i);
    kind_t k;
    k = K_OTHER;
    case (i[31:26])
      6'h00: begin
        if (i[5:0] == 6'h00 || i[5:0] == 6'h02 || i[5:0] == 6'h03) k = K_SHIFT;
        else if (i[5:0] == 6'h08) k = K_JR;
        else if (i[5:0] == 6'h09) k = K_JALR;
        else k = K_RTYPE;
      end
      6'h01: k = (i[20:16] == 5'd0) ? K_BLTZ : (i[20:16] == 5'd1) ? K_BGEZ : K_OTHER;
      6'h02: k = K_J;
      6'h03: k = K_JAL;
      6'h04: k = K_BEQ;
      6'h05: k = K_BNE;
      6'h06: k = K_BLEZ;
      6'h07: k = K_BGTZ;
      6'h0F: k = K_LUI;
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: k = K_STORE;
      default: k = K_OTHER;
    endcase
    return k;
  endfunction

  function automatic bit pending(input logic [4:0] r);
    return (r != 5'd0) && (r == dif.EXE_wdest || r == dif.MEM_wdest || r == dif.WB_wdest);
  endfunction

  function automatic bit m_hazard();
    kind_t k;
    bit rsu, rtu;
    k = classify(m_inst);
    rsu = !(k inside {K_J, K_JAL, K_LUI, K_SHIFT});
    rtu = k inside {K_RTYPE, K_SHIFT, K_JR, K_JALR, K_BEQ, K_BNE, K_STORE};
    return m_valid && ((rsu && pending(m_inst[25:21])) || (rtu && pending(m_inst[20:16])));
  endfunction

  // Expected {taken, target} from instruction semantics on the current operands.
  function automatic logic [32:0] m_jbr(input bit over);
    kind_t k;
    bit t;
    logic signed [31:0] a, b;
    logic [31:0] seqv, tgt;
    k = classify(m_inst);
    a = $signed(dif.rs_value);
    b = $signed(dif.rt_value);
    seqv = m_pc + 32'd4;
    tgt = seqv + ({{16{m_inst[15]}}, m_inst[15:0]} << 2);
    t = 1'b0;
    case (k)
      K_BEQ:  t = (a == b);
      K_BNE:  t = (a != b);
      K_BGEZ: t = (a >= 0);
      K_BLTZ: t = (a < 0);
      K_BGTZ: t = (a > 0);
      K_BLEZ: t = (a <= 0);
      K_J, K_JAL: begin t = 1'b1; tgt = {seqv[31:28], m_inst[25:0], 2'b00}; end
      K_JR, K_JALR: begin t = 1'b1; tgt = dif.rs_value; end
      default: t = 1'b0;
    endcase
    if (over && t) return {1'b1, tgt};
    return 33'd0;
  endfunction

  task automatic check_model(input string tag);
    bit over, allow;
    over  = m_valid && !m_hazard() && !dif.cancel;
    allow = !m_valid || (over && dif.EXE_allow_in);
    chk({tag, ".rs"}, 128'(dif.rs), 128'(m_inst[25:21]));
    chk({tag, ".rt"}, 128'(dif.rt), 128'(m_inst[20:16]));
    chk({tag, ".ID_over"}, 128'(dif.ID_over), 128'(over));
    chk({tag, ".ID_allow_in"}, 128'(dif.ID_allow_in), 128'(allow));
    chk({tag, ".jbr_bus"}, 128'(dif.jbr_bus), 128'(m_jbr(over)));
    chk({tag, ".ID_EXE_bus"}, dif.ID_EXE_bus, {m_pc, m_inst, dif.rs_value, dif.rt_value});
`ifdef ID_STALL_CNT_EN
    chk({tag, ".stall_cnt"}, 128'(dif.stall_cnt), 128'(m_cnt));
`else
    chk({tag, ".stall_cnt"}, 128'(dif.stall_cnt), 128'(0));
`endif
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_pc = 32'd0; m_inst = 32'd0; m_cnt = '0;
  endtask

  task automatic model_update();
    bit haz, over, allow;
    if (!resetn) begin
      model_reset();
      return;
    end
    haz   = m_hazard();
    over  = m_valid && !haz && !dif.cancel;
    allow = !m_valid || (over && dif.EXE_allow_in);
    if (haz && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    if (dif.cancel) m_valid = 1'b0;
    else if (dif.IF_over && allow) begin
      m_valid = 1'b1;
      m_pc    = dif.IF_ID_bus[63:32];
      m_inst  = dif.IF_ID_bus[31:0];
    end else if (over && dif.EXE_allow_in) m_valid = 1'b0;
  endtask

  task automatic step_begin(input string tag);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic step_end();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    dif.IF_over = 1'b0; dif.IF_ID_bus = 64'd0; dif.cancel = 1'b0; dif.EXE_allow_in = 1'b1;
    dif.EXE_wdest = 5'd0; dif.MEM_wdest = 5'd0; dif.WB_wdest = 5'd0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  a, b;
    logic [15:0] imm;
    logic [31:0] i;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 17))
      0:  i = {6'h00, a, b, 5'($urandom_range(1, 7)), 5'd0, 6'h21};
      1:  i = {6'h00, a, b, 5'd3, 5'd2, 6'h00};
      2:  i = {6'h00, a, b, 5'd3, 5'd2, 6'h03};
      3:  i = {6'h0F, a, b, imm};
      4:  i = {6'h2B, a, b, imm};
      5:  i = {6'h23, a, b, imm};
      6:  i = {6'h04, a, b, imm};
      7:  i = {6'h05, a, b, imm};
      8:  i = {6'h06, a, b, imm};
      9:  i = {6'h07, a, b, imm};
      10: i = {6'h01, a, 5'd0, imm};
      11: i = {6'h01, a, 5'd1, imm};
      12: i = {6'h01, a, 5'h10, imm};
      13: i = {6'h02, 26'($urandom)};
      14: i = {6'h03, 26'($urandom)};
      15: i = {6'h00, a, b, 5'd0, 5'd0, 6'h08};
      16: i = {6'h00, a, b, 5'd31, 5'd0, 6'h09};
      default: i = {6'h0D, a, b, imm};
    endcase
    return i;
  endfunction

  localparam logic [31:0] ADDU = 32'h0022_1821;  // addu $3,$1,$2

  initial begin
    resetn = 1'b0;
    idle();
    dif.rs_value = 32'd0;
    dif.rt_value = 32'd0;
    model_reset();

    // reset state
    #1;
    step_begin("rst");
    chk("rst.allow", 128'(dif.ID_allow_in), 128'(1));
    chk("rst.over", 128'(dif.ID_over), 128'(0));
    chk("rst.jbr", 128'(dif.jbr_bus), 128'(0));
    chk("rst.bus_hi", 128'(dif.ID_EXE_bus[127:64]), 128'(0));
    step_end();
    resetn = 1'b1;

    // ADDU hazard-free: ready one cycle after latch
    dif.IF_over = 1'b1; dif.IF_ID_bus = {32'h34, ADDU};
    dif.rs_value = 32'h1111; dif.rt_value = 32'h2222;
    step_begin("addu.latch"); step_end();
    dif.IF_over = 1'b0;
    step_begin("addu.ready");
    chk("addu.over", 128'(dif.ID_over), 128'(1));
    chk("addu.rs", 128'(dif.rs), 128'(1));
    chk("addu.rt", 128'(dif.rt), 128'(2));
    step_end();

    // ADDU stalled two cycles on EXE_wdest=2; fetch offers another meanwhile
    dif.IF_over = 1'b1; dif.IF_ID_bus = {32'h34, ADDU};
    step_begin("stall.latch"); step_end();
    dif.EXE_wdest = 5'd2; dif.IF_ID_bus = {32'h999, 32'hFFFF_FFFF};
    for (int c = 0; c < 2; c++) begin
      step_begin("stall.hold");
      chk("stall.over", 128'(dif.ID_over), 128'(0));
      chk("stall.allow", 128'(dif.ID_allow_in), 128'(0));
      chk("stall.pc", 128'(dif.ID_EXE_bus[127:96]), 128'(32'h34));
      step_end();
    end
    dif.EXE_wdest = 5'd0; dif.IF_over = 1'b0;
    step_begin("stall.release");
    chk("stall.over_rel", 128'(dif.ID_over), 128'(1));
`ifdef ID_STALL_CNT_EN
    chk("stall.cnt", 128'(dif.stall_cnt), 128'(2));
`else
    chk("stall.cnt", 128'(dif.stall_cnt), 128'(0));
`endif
    step_end();

    // BEQ taken, then BNE not taken, then J and JR
    dif.IF_over = 1'b1; dif.IF_ID_bus = {32'h40, 32'h1021_FFFF};
    dif.rs_value = 32'h1234; dif.rt_value = 32'h1234;
    step_begin("beq.latch"); step_end();
    dif.IF_ID_bus = {32'h40, 32'h1421_FFFF};
    step_begin("beq.resolve");
    chk("beq.jbr", 128'(dif.jbr_bus), 128'({1'b1, 32'h40}));
    step_end();
    dif.IF_ID_bus = {32'hF000_0000, 32'h0800_0010};
    step_begin("bne.resolve");
    chk("bne.jbr", 128'(dif.jbr_bus), 128'(0));
    step_end();
    dif.IF_ID_bus = {32'h0000_0200, 32'h03E0_0008};
    step_begin("j.resolve");
    chk("j.jbr", 128'(dif.jbr_bus), 128'({1'b1, 32'hF000_0040}));
    step_end();
    dif.IF_over = 1'b0; dif.rs_value = 32'h80;
    step_begin("jr.resolve");
    chk("jr.jbr", 128'(dif.jbr_bus), 128'({1'b1, 32'h80}));
    step_end();

    // cancel kills held instruction and blocks the offered one
    dif.IF_over = 1'b1; dif.IF_ID_bus = {32'h100, ADDU}; dif.EXE_allow_in = 1'b0;
    step_begin("cancel.latch"); step_end();
    dif.IF_ID_bus = {32'h200, ADDU}; dif.cancel = 1'b1; dif.EXE_allow_in = 1'b1;
    step_begin("cancel.assert");
    chk("cancel.over", 128'(dif.ID_over), 128'(0));
    chk("cancel.jbr", 128'(dif.jbr_bus), 128'(0));
    step_end();
    dif.cancel = 1'b0; dif.IF_over = 1'b0;
    step_begin("cancel.after");
    chk("cancel.allow", 128'(dif.ID_allow_in), 128'(1));
    chk("cancel.over2", 128'(dif.ID_over), 128'(0));
    chk("cancel.pc", 128'(dif.ID_EXE_bus[127:96]), 128'(32'h100));
    step_end();

    // asynchronous reset in the middle of a stall
    dif.IF_over = 1'b1; dif.IF_ID_bus = {32'h34, ADDU};
    step_begin("rst2.latch"); step_end();
    dif.IF_over = 1'b0; dif.EXE_wdest = 5'd2;
    step_begin("rst2.stall");
    #2 resetn = 1'b0;
    #1;
    chk("rst2.allow", 128'(dif.ID_allow_in), 128'(1));
    chk("rst2.over", 128'(dif.ID_over), 128'(0));
    chk("rst2.jbr", 128'(dif.jbr_bus), 128'(0));
    chk("rst2.bus_hi", 128'(dif.ID_EXE_bus[127:64]), 128'(0));
    model_reset();
    step_end();
    resetn = 1'b1;
    idle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      dif.IF_over      = ($urandom_range(0, 3) != 0);
      dif.IF_ID_bus    = {($urandom & 32'hFFFF_FFFC), rand_inst()};
      dif.cancel       = ($urandom_range(0, 15) == 0);
      dif.EXE_allow_in = ($urandom_range(0, 3) != 0);
      dif.EXE_wdest    = 5'($urandom_range(0, 7));
      dif.MEM_wdest    = 5'($urandom_range(0, 7));
      dif.WB_wdest     = 5'($urandom_range(0, 7));
      dif.rt_value     = $urandom;
      case ($urandom_range(0, 3))
        0: dif.rs_value = 32'd0;
        1: dif.rs_value = dif.rt_value;
        2: dif.rs_value = 32'h8000_0000 | $urandom;
        default: dif.rs_value = $urandom;
      endcase
      step_begin("rand");
      step_end();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
